// File: rtl/matmul_pkg.sv
// Shared constants, command encodings, address map and controller states for the
// systolic matrix-multiply sequencer.
package matmul_pkg;
  localparam int N    = 3;
  localparam int DW   = 16;
  localparam int ACCW = 32;
  localparam logic signed [DW-1:0] THRESH_RST = -16'sd70;

  localparam int RUN_CYCLES = 3 * N - 2;
  localparam int CYCW       = $clog2(RUN_CYCLES);

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_CLEAR = 2'b01;
  localparam logic [1:0] OP_START = 2'b10;
  localparam logic [1:0] OP_READ  = 2'b11;

  localparam logic [4:0] A_BASE    = 5'd0;
  localparam logic [4:0] B_BASE    = 5'd9;
  localparam logic [4:0] BIAS_BASE = 5'd18;
  localparam logic [4:0] THR_ADDR  = 5'd27;
  localparam logic [4:0] MASK_ADDR = 5'd28;

  typedef enum logic [1:0] {IDLE, RUN, CAPTURE, DONE} state_e;
endpackage

// File: rtl/systolic_skew_feed.sv
// Skewed edge feeds: row r of A and column c of B enter the grid r (or c) cycles late,
// so PE(i,j) sees A[i][k] and B[k][j] together at cycle i+j+k.
module systolic_skew_feed
  import matmul_pkg::*;
(
  input  logic                  run_i,
  input  logic [CYCW-1:0]       cyc_i,
  input  logic [N*N*DW-1:0]     a_i,
  input  logic [N*N*DW-1:0]     b_i,
  output logic [N*DW-1:0]       feed_a_o,
  output logic [N*DW-1:0]       feed_b_o
);

  always_comb begin
    feed_a_o = '0;
    feed_b_o = '0;
    if (run_i) begin
      for (int e = 0; e < N; e++) begin
        for (int k = 0; k < N; k++) begin
          if (cyc_i == CYCW'(e + k)) begin
            feed_a_o[e*DW +: DW] = a_i[(e*N + k)*DW +: DW];
            feed_b_o[e*DW +: DW] = b_i[(k*N + e)*DW +: DW];
          end
        end
      end
    end
  end

endmodule

// File: rtl/systolic_mm_sequencer.sv
// Operand store and run controller for the NxN output-stationary PE array: accepts
// PCPI-side commands, drives the skewed feed schedule, captures and thresholds results.
module systolic_mm_sequencer
  import matmul_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [4:0]             cmd_addr,
  input  logic [DW-1:0]          cmd_data,
  output logic                   rsp_valid,
  output logic [31:0]            rsp_data,
  output logic [N*DW-1:0]        feed_a,
  output logic [N*DW-1:0]        feed_b,
  output logic                   pe_en,
  output logic                   pe_load_bias,
  output logic [N*N*DW-1:0]      bias_out,
  input  logic [N*N*ACCW-1:0]    acc_in,
  output logic                   busy
);

  state_e                 state_q, state_d;
  logic [CYCW-1:0]        cyc_q, cyc_d;
  logic [N*N*DW-1:0]      a_q, a_d, b_q, b_d, bias_q, bias_d;
  logic signed [DW-1:0]   thr_q, thr_d;
  logic [N*N*ACCW-1:0]    acc_q, acc_d;
  logic [N*N-1:0]         mask_q, mask_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [31:0]            rsp_data_q, rsp_data_d;
  logic signed [ACCW-1:0] thr_ext;

  assign thr_ext = {{(ACCW-DW){thr_q[DW-1]}}, thr_q};

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    a_d         = a_q;
    b_d         = b_q;
    bias_d      = bias_q;
    thr_d       = thr_q;
    acc_d       = acc_q;
    mask_d      = mask_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = '0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_WRITE: begin
              rsp_valid_d = 1'b1;
              if (cmd_addr < B_BASE)
                a_d[int'(cmd_addr - A_BASE)*DW +: DW] = cmd_data;
              else if (cmd_addr < BIAS_BASE)
                b_d[int'(cmd_addr - B_BASE)*DW +: DW] = cmd_data;
              else if (cmd_addr < THR_ADDR)
                bias_d[int'(cmd_addr - BIAS_BASE)*DW +: DW] = cmd_data;
              else if (cmd_addr == THR_ADDR)
                thr_d = cmd_data;
            end
            OP_CLEAR: begin
              rsp_valid_d = 1'b1;
              a_d         = '0;
              b_d         = '0;
              bias_d      = '0;
              acc_d       = '0;
              mask_d      = '0;
              thr_d       = THRESH_RST;
            end
            OP_READ: begin
              rsp_valid_d = 1'b1;
              if (cmd_addr < B_BASE)
                rsp_data_d = acc_q[int'(cmd_addr)*ACCW +: ACCW];
              else if (cmd_addr == THR_ADDR)
                rsp_data_d = thr_ext;
              else if (cmd_addr == MASK_ADDR)
                rsp_data_d = {{(32-N*N){1'b0}}, mask_q};
            end
            default: begin
              state_d = RUN;
              cyc_d   = '0;
            end
          endcase
        end
      end
      RUN: begin
        cyc_d = cyc_q + CYCW'(1);
        if (cyc_q == CYCW'(RUN_CYCLES - 1))
          state_d = CAPTURE;
      end
      CAPTURE: begin
        acc_d = acc_in;
        for (int i = 0; i < N*N; i++)
          mask_d[i] = $signed(acc_in[i*ACCW +: ACCW]) >= thr_ext;
        // Response is registered here so it appears during DONE.
        rsp_valid_d = 1'b1;
        rsp_data_d  = {{(32-N*N){1'b0}}, mask_d};
        state_d     = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cyc_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      bias_q      <= '0;
      thr_q       <= THRESH_RST;
      acc_q       <= '0;
      mask_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      a_q         <= a_d;
      b_q         <= b_d;
      bias_q      <= bias_d;
      thr_q       <= thr_d;
      acc_q       <= acc_d;
      mask_q      <= mask_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign cmd_ready    = (state_q == IDLE);
  assign busy         = (state_q == RUN) || (state_q == CAPTURE);
  assign pe_en        = (state_q == RUN);
  assign pe_load_bias = (state_q == RUN) && (cyc_q == '0);
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign bias_out     = bias_q;

  systolic_skew_feed u_feed (
    .run_i    (state_q == RUN),
    .cyc_i    (cyc_q),
    .a_i      (a_q),
    .b_i      (b_q),
    .feed_a_o (feed_a),
    .feed_b_o (feed_b)
  );

endmodule

// File: tb/tb_systolic_mm_sequencer.sv
// Bench for systolic_mm_sequencer: a behavioural PE grid closes the loop from feeds to
// acc_in; results are predicted with plain matrix arithmetic on a shadow operand store.
module tb_systolic_mm_sequencer;
  import matmul_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  cmd_valid, cmd_ready;
  logic [1:0]            cmd_op;
  logic [4:0]            cmd_addr;
  logic [DW-1:0]         cmd_data;
  logic                  rsp_valid;
  logic [31:0]           rsp_data;
  logic [N*DW-1:0]       feed_a, feed_b;
  logic                  pe_en, pe_load_bias, busy;
  logic [N*N*DW-1:0]     bias_out;
  logic [N*N*ACCW-1:0]   acc_in;

  int n_checks = 0;
  int n_fail   = 0;

  int ma[N*N], mb[N*N], mbias[N*N], macc[N*N];
  int mthr;
  logic [N*N-1:0] mmask;

  int ga[N][N], gb[N][N], gacc[N][N];
  logic [N*DW-1:0] fa_log [3*N+4];

  typedef struct {
    logic [1:0]  op;
    int          addr;
    int          data;
    logic [31:0] exp;
  } vec_t;
  vec_t tv[12];

  always #5 clk = ~clk;

  systolic_mm_sequencer dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .feed_a(feed_a), .feed_b(feed_b),
    .pe_en(pe_en), .pe_load_bias(pe_load_bias), .bias_out(bias_out),
    .acc_in(acc_in), .busy(busy)
  );

  // Output-stationary PE grid: A flows east, B flows south, accumulator stays put.
  function automatic int a_in(input int i, input int j);
    if (j == 0) return int'($signed(feed_a[i*DW +: DW]));
    return ga[i][j-1];
  endfunction
  function automatic int b_in(input int i, input int j);
    if (i == 0) return int'($signed(feed_b[j*DW +: DW]));
    return gb[i-1][j];
  endfunction
  function automatic int bias_at(input int i, input int j);
    return int'($signed(bias_out[(i*N+j)*DW +: DW]));
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          ga[i][j]   <= 0;
          gb[i][j]   <= 0;
          gacc[i][j] <= 0;
        end
    end else if (pe_en) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          ga[i][j]   <= a_in(i, j);
          gb[i][j]   <= b_in(i, j);
          gacc[i][j] <= (pe_load_bias ? bias_at(i, j) : gacc[i][j]) + a_in(i, j) * b_in(i, j);
        end
    end
  end

  always_comb begin
    acc_in = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        acc_in[(i*N+j)*ACCW +: ACCW] = gacc[i][j];
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic int sx(input int v);
    logic signed [DW-1:0] t;
    t = v[DW-1:0];
    return int'(t);
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < N*N; i++) begin
      ma[i] = 0; mb[i] = 0; mbias[i] = 0; macc[i] = 0;
    end
    mthr  = -70;
    mmask = '0;
  endfunction

  function automatic logic [31:0] exp_read(input int a);
    if (a < N*N) return macc[a];
    if (a == 27) return mthr;
    if (a == 28) return {23'b0, mmask};
    return 32'h0;
  endfunction

  function automatic logic [N*DW-1:0] exp_feed_a(input int cyc);
    logic [N*DW-1:0] f;
    int t;
    f = '0;
    for (int r = 0; r < N; r++) begin
      int k;
      k = cyc - r;
      if (cyc < RUN_CYCLES && k >= 0 && k < N) begin
        t = ma[r*N + k];
        f[r*DW +: DW] = t[DW-1:0];
      end
    end
    return f;
  endfunction

  function automatic logic [N*DW-1:0] exp_feed_b(input int cyc);
    logic [N*DW-1:0] f;
    int t;
    f = '0;
    for (int c = 0; c < N; c++) begin
      int k;
      k = cyc - c;
      if (cyc < RUN_CYCLES && k >= 0 && k < N) begin
        t = mb[k*N + c];
        f[c*DW +: DW] = t[DW-1:0];
      end
    end
    return f;
  endfunction

  task automatic do_cmd(input logic [1:0] op, input int addr, input int data, output logic [31:0] rsp);
    int w;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr[4:0];
    cmd_data  = data[DW-1:0];
    w = 0;
    while (!cmd_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk("cmd accepted", cmd_ready, 1'b1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk("rsp pulse", rsp_valid, 1'b1);
    rsp = rsp_data;
    if (op == OP_WRITE) begin
      if (addr < 9)       ma[addr]       = sx(data);
      else if (addr < 18) mb[addr-9]     = sx(data);
      else if (addr < 27) mbias[addr-18] = sx(data);
      else if (addr == 27) mthr          = sx(data);
    end else if (op == OP_CLEAR) begin
      model_clear();
    end
  endtask

  task automatic wr(input int a, input int d);
    logic [31:0] r;
    do_cmd(OP_WRITE, a, d, r);
    chk("write rsp", r, 32'h0);
  endtask

  task automatic rd(input int a, input logic [31:0] exp);
    logic [31:0] r;
    do_cmd(OP_READ, a, 0, r);
    chk($sformatf("read %0d", a), r, exp);
  endtask

  task automatic do_start(input bit hold_wr, input int wr_addr, input int wr_data);
    int eacc[N*N];
    logic [31:0] emask;
    int s, cyc, lat, pe_cnt;
    emask = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        s = mbias[i*N+j];
        for (int k = 0; k < N; k++) s += ma[i*N+k] * mb[k*N+j];
        eacc[i*N+j]  = s;
        emask[i*N+j] = (s >= mthr);
      end
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = OP_START;
    cmd_addr  = '0;
    cmd_data  = '0;
    chk("start ready", cmd_ready, 1'b1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    if (hold_wr) begin
      cmd_valid = 1'b1;
      cmd_op    = OP_WRITE;
      cmd_addr  = wr_addr[4:0];
      cmd_data  = wr_data[DW-1:0];
    end
    lat = 1;
    pe_cnt = 0;
    while (lat <= 3*N + 4) begin
      cyc = lat - 1;
      fa_log[cyc] = feed_a;
      chk($sformatf("feed_a cyc%0d", cyc), feed_a, exp_feed_a(cyc));
      chk($sformatf("feed_b cyc%0d", cyc), feed_b, exp_feed_b(cyc));
      chk($sformatf("pe_en cyc%0d", cyc), pe_en, cyc < RUN_CYCLES);
      chk($sformatf("pe_load_bias cyc%0d", cyc), pe_load_bias, cyc == 0);
      chk($sformatf("busy cyc%0d", cyc), busy, cyc <= RUN_CYCLES);
      if (hold_wr) chk("ready blocked", cmd_ready, 1'b0);
      if (pe_en) pe_cnt++;
      if (rsp_valid) break;
      @(posedge clk);
      #1;
      lat++;
    end
    chk("start latency", lat, 3*N);
    chk("run length", pe_cnt, RUN_CYCLES);
    chk("result mask", rsp_data, emask);
    for (int i = 0; i < N*N; i++) macc[i] = eacc[i];
    mmask = emask[N*N-1:0];
  endtask

  initial begin
    logic [31:0] r;
    int pulses;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_data = '0;
    model_clear();

    tv[0]  = '{OP_READ,  27, 0,  32'hFFFF_FFBA};
    tv[1]  = '{OP_READ,  28, 0,  32'h0};
    tv[2]  = '{OP_READ,  5,  0,  32'h0};
    tv[3]  = '{OP_WRITE, 27, 5,  32'h0};
    tv[4]  = '{OP_READ,  27, 0,  32'h5};
    tv[5]  = '{OP_WRITE, 27, -3, 32'h0};
    tv[6]  = '{OP_READ,  27, 0,  32'hFFFF_FFFD};
    tv[7]  = '{OP_WRITE, 30, 77, 32'h0};
    tv[8]  = '{OP_READ,  30, 0,  32'h0};
    tv[9]  = '{OP_WRITE, 18, -5, 32'h0};
    tv[10] = '{OP_CLEAR, 0,  0,  32'h0};
    tv[11] = '{OP_READ,  27, 0,  32'hFFFF_FFBA};

    repeat (3) @(posedge clk);
    #1;
    chk("rst cmd_ready", cmd_ready, 1'b1);
    chk("rst rsp_valid", rsp_valid, 1'b0);
    chk("rst rsp_data", rsp_data, 32'h0);
    chk("rst busy", busy, 1'b0);
    chk("rst pe_en", pe_en, 1'b0);
    chk("rst feed_a", feed_a, '0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      do_cmd(tv[i].op, tv[i].addr, tv[i].data, r);
      chk($sformatf("vec %0d", i), r, tv[i].exp);
    end

    // Identity A, B = 1..9, threshold 5.
    for (int i = 0; i < N*N; i++) wr(i, (i % 4 == 0) ? 1 : 0);
    for (int i = 0; i < N*N; i++) wr(9 + i, i + 1);
    wr(27, 5);
    do_start(1'b0, 0, 0);
    rd(28, 32'h1F0);
    rd(4, 32'h5);
    rd(8, 32'h9);

    // Zero operands, bias -10, default threshold.
    do_cmd(OP_CLEAR, 0, 0, r);
    for (int i = 0; i < N*N; i++) wr(18 + i, -10);
    do_start(1'b0, 0, 0);
    rd(28, 32'h1FF);
    rd(0, 32'hFFFF_FFF6);

    // Skew schedule with A = 1..9.
    do_cmd(OP_CLEAR, 0, 0, r);
    for (int i = 0; i < N*N; i++) wr(i, i + 1);
    for (int i = 0; i < N*N; i++) wr(9 + i, 9 - i);
    do_start(1'b0, 0, 0);
    chk("skew cyc2", fa_log[2], {16'sd7, 16'sd5, 16'sd3});
    chk("skew cyc4 row0", fa_log[4][0 +: DW], 16'h0);
    chk("skew cyc4 row2", fa_log[4][2*DW +: DW], 16'h9);
    rd(28, exp_read(28));

    // A write held during a run waits, then lands afterwards.
    do_start(1'b1, 0, 100);
    do_cmd(OP_WRITE, 0, 100, r);
    chk("held write rsp", r, 32'h0);
    do_start(1'b0, 0, 0);
    rd(0, exp_read(0));

    // Asynchronous reset in the middle of a run.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = OP_START;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("pre-reset busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("arst cmd_ready", cmd_ready, 1'b1);
    chk("arst rsp_valid", rsp_valid, 1'b0);
    chk("arst rsp_data", rsp_data, 32'h0);
    chk("arst busy", busy, 1'b0);
    chk("arst pe_en", pe_en, 1'b0);
    chk("arst pe_load_bias", pe_load_bias, 1'b0);
    chk("arst feed_a", feed_a, '0);
    chk("arst feed_b", feed_b, '0);
    chk("arst bias_out", bias_out, '0);
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (rsp_valid) pulses++;
    end
    chk("no rsp after reset", pulses, 0);
    rd(27, 32'hFFFF_FFBA);
    do_start(1'b0, 0, 0);
    rd(28, 32'h1FF);

    // Randomised operands against the arithmetic model.
    for (int it = 0; it < 5; it++) begin
      for (int i = 0; i < 27; i++) wr(i, int'($urandom_range(600)) - 300);
      wr(27, int'($urandom_range(4000)) - 2000);
      do_start(1'b0, 0, 0);
      rd(28, exp_read(28));
      for (int k = 0; k < 3; k++) begin
        int a;
        a = int'($urandom_range(N*N - 1));
        rd(a, exp_read(a));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_mm_sequencer.md
Name: systolic_mm_sequencer

Overview:
Controller for the NxN output-stationary systolic matrix-multiply PE array behind the custom PCPI opcode. It holds the A, B, bias and threshold operand store. On command it sequences the array through its skewed feed schedule and captures the accumulators. It then returns the thresholded result mask. It sits between the PCPI instruction decoder (command side) and the PE grid (datapath side).

Parameters:
N, 3, array dimension (NxN operands and PEs)
DW, 16, signed operand/bias width
ACCW, 32, signed accumulator width
THRESH_RST, -70, threshold value after reset/clear

Ports:
clk  in  1  clock
rst  in  1  async active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when valid&ready
cmd_op  in  2  00 WRITE, 01 CLEAR, 10 START, 11 READ
cmd_addr  in  5  operand/result address
cmd_data  in  DW  write data (signed)
rsp_valid  out  1  one-cycle response pulse
rsp_data  out  32  response payload
feed_a  out  N*DW  west-edge A inputs, row r at [r*DW +: DW]
feed_b  out  N*DW  north-edge B inputs, col c at [c*DW +: DW]
pe_en  out  1  PE array clock-enable
pe_load_bias  out  1  PEs take c_in from bias_out this cycle
bias_out  out  N*N*DW  bias matrix, element (i,j) at [(i*N+j)*DW +: DW]
acc_in  in  N*N*ACCW  PE accumulator outputs, same packing
busy  out  1  high in RUN/CAPTURE

Behaviour:
- Reset (async, rst=1): state IDLE, cyc=0, A/B/bias=0, threshold=THRESH_RST, mask=0, acc capture regs=0. Outputs: cmd_ready=1, rsp_valid=0, rsp_data=0, feeds=0, pe_en=0, pe_load_bias=0, busy=0.
- Address map: 0..8 A[a/3][a%3]; 9..17 B[(a-9)/3][(a-9)%3]; 18..26 bias; 27 threshold (sign-extended to 32b); 28 result mask (READ only). WRITE to 28..31 is ignored and still acked.
- States: IDLE -> RUN (START accepted) -> CAPTURE (last RUN cycle) -> DONE -> IDLE.
- cmd_ready=1 only in IDLE. Commands are never queued; a valid during busy simply waits.
- WRITE/CLEAR: register updated on the accept edge. rsp_valid pulses the next cycle with rsp_data=0. CLEAR zeroes A, B, bias, mask and acc regs, and restores threshold=THRESH_RST.
- READ: rsp_valid the next cycle. rsp_data = acc reg (addr 0..8), threshold (27), {23'b0,mask} (28), else 0.
- RUN: lasts exactly 3N-2 cycles, cyc=0..3N-3. pe_en=1 throughout. pe_load_bias=1 only at cyc=0.
  - feed_a[r] = A[r][cyc-r] if r<=cyc<r+N, else 0.
  - feed_b[c] = B[cyc-c][c] if c<=cyc<c+N, else 0.
  - Outside RUN: feeds=0, pe_en=0.
- CAPTURE (1 cycle, pe_en=0): latch all acc_in into acc regs. mask bit (i*N+j) = signed(acc_in(i,j)) >= signed threshold.
- DONE (1 cycle): rsp_valid=1, rsp_data={23'b0,mask}; return to IDLE.
- Latency: START accepted at edge T -> rsp_valid high in cycle T+3N (9 for N=3).
- Operands are stable during RUN because writes are blocked. Reset mid-RUN aborts immediately to the reset state, with no rsp_valid.
- Arithmetic: all compares signed ACCW-bit; threshold stored as DW and sign-extended.

Decomposition:
- Shared package matmul_pkg holds:
  - N, DW, ACCW, THRESH_RST
  - cmd_op encodings
  - address-map constants (A_BASE=0, B_BASE=9, BIAS_BASE=18, THR_ADDR=27, MASK_ADDR=28)
  - state enum (IDLE, RUN, CAPTURE, DONE)
- One natural sub-module, systolic_skew_feed: combinational plus a valid gate. Inputs are cyc, the A and B stores and run. Outputs are feed_a and feed_b.

Test Plan:
- Reset then READ 27 -> rsp_data=0xFFFFFFBA (-70); READ 28 -> 0.
- A=I, B=[1..9] row-major, bias=0, threshold=5, START -> rsp_valid exactly 9 cycles after accept, mask=0x1F0. READ 4 -> 5; READ 8 -> 9.
- A=B=0, bias all -10, threshold default -70, START -> mask=0x1FF. READ 0 -> 0xFFFFFFF6. Check pe_load_bias is high only in the first RUN cycle.
- Skew check, A=[[1,2,3],[4,5,6],[7,8,9]]: at cyc=2, feed_a = {A[0][2]=3, A[1][1]=5, A[2][0]=7}. At cyc=4, feed_a row0=0 and row2=9. All feeds are 0 after RUN.
- Hold a WRITE valid during RUN -> cmd_ready=0 until IDLE; the write then lands after completion. The result uses the old operand value.
- Assert rst at cyc=3 -> all outputs at reset values asynchronously, no rsp_valid. The next START runs a full 7-cycle RUN.
